// File: rtl/uart_transceiver_param_pkg.sv
// Shared definitions for the parametrised UART: frame states and
// the baud divider calculation.
package uart_transceiver_param_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_st_e;

   function automatic int calc_div(input int clk_freq,
                                   input int baud,
                                   input int os);
      int d;
      d = (clk_freq + baud * os / 2) / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_transceiver_param_baud_tick.sv
// Free-running oversample tick generator shared by the TX and RX paths.
// Pulses for one clock each time the divider wraps.
module uart_baud_tick
   import uart_transceiver_param_pkg::*;
#(
   parameter int CLK_FREQ   = 25_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_transceiver_param.sv
// Parametrised full-duplex UART: valid/ready TX path and mid-bit
// sampling RX path with glitch reject, parity and framing checks.
module uart_transceiver_param
   import uart_transceiver_param_pkg::*;
#(
   parameter int CLK_FREQ   = 25_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] STOP_END = CW'(OVERSAMPLE - 2);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic PAR_EN    = (PARITY_EN != 0);
   localparam logic PAR_ODD   = (PARITY_ODD != 0);
   localparam logic LAST_STOP = (STOP_BITS == 2);

   logic tick;

   uart_baud_tick #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   uart_st_e             tx_st_q, tx_st_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_stop_q, tx_stop_d;
   logic                 txd_q, txd_d;
   logic                 tx_rdy_q, tx_rdy_d;
   logic                 tx_done;

   // The frame ends one tick early so a back-to-back accept lands its
   // start bit right after a full-length stop bit.
   always_comb begin
      tx_st_d   = tx_st_q;
      tx_cnt_d  = tx_cnt_q;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      tx_par_d  = tx_par_q;
      tx_stop_d = tx_stop_q;
      txd_d     = txd_q;
      tx_rdy_d  = tx_rdy_q;
      tx_done   = tick && (tx_cnt_q == BIT_END);
      if (tx_st_q != ST_IDLE && tick)
         tx_cnt_d = tx_done ? '0 : tx_cnt_q + 1'b1;
      unique case (tx_st_q)
         ST_IDLE: if (tx_valid && tx_rdy_q) begin
            tx_st_d  = ST_START;
            tx_cnt_d = '0;
            tx_sh_d  = tx_data;
            tx_par_d = (^tx_data) ^ PAR_ODD;
            txd_d    = 1'b0;
            tx_rdy_d = 1'b0;
         end
         ST_START: if (tx_done) begin
            tx_st_d  = ST_DATA;
            tx_bit_d = '0;
            txd_d    = tx_sh_q[0];
         end
         ST_DATA: if (tx_done) begin
            if (tx_bit_q == LAST_BIT) begin
               if (PAR_EN) begin
                  tx_st_d = ST_PARITY;
                  txd_d   = tx_par_q;
               end else begin
                  tx_st_d   = ST_STOP;
                  txd_d     = 1'b1;
                  tx_stop_d = 1'b0;
               end
            end else begin
               tx_bit_d = tx_bit_q + 1'b1;
               tx_sh_d  = tx_sh_q >> 1;
               txd_d    = tx_sh_q[1];
            end
         end
         ST_PARITY: if (tx_done) begin
            tx_st_d   = ST_STOP;
            txd_d     = 1'b1;
            tx_stop_d = 1'b0;
         end
         ST_STOP: begin
            if (tick && tx_stop_q == LAST_STOP && tx_cnt_q == STOP_END) begin
               tx_st_d  = ST_IDLE;
               tx_rdy_d = 1'b1;
            end else if (tx_done) begin
               tx_stop_d = 1'b1;
            end
         end
         default: tx_st_d = ST_IDLE;
      endcase
   end

   logic                 rx_s1_q, rx_s2_q, rx_prev_q;
   uart_st_e             rx_st_q, rx_st_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_par_q, rx_par_d;
   logic                 rx_vld_q, rx_vld_d;
   logic                 rx_fe_q, rx_fe_d;
   logic                 rx_pe_q, rx_pe_d;
   logic                 rx_smp;

   // A low line after a bad stop bit leaves rx_prev_q low, so no new
   // start is armed until the line has been seen high again.
   always_comb begin
      rx_st_d   = rx_st_q;
      rx_cnt_d  = rx_cnt_q;
      rx_bit_d  = rx_bit_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      rx_par_d  = rx_par_q;
      rx_fe_d   = rx_fe_q;
      rx_pe_d   = rx_pe_q;
      rx_vld_d  = 1'b0;
      rx_smp    = tick &&
                  (rx_cnt_q == ((rx_st_q == ST_START) ? HALF_END : BIT_END));
      if (rx_st_q != ST_IDLE && tick)
         rx_cnt_d = rx_smp ? '0 : rx_cnt_q + 1'b1;
      unique case (rx_st_q)
         ST_IDLE: if (rx_prev_q && !rx_s2_q) begin
            rx_st_d  = ST_START;
            rx_cnt_d = '0;
         end
         ST_START: if (rx_smp) begin
            rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
            rx_bit_d = '0;
         end
         ST_DATA: if (rx_smp) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT)
               rx_st_d = PAR_EN ? ST_PARITY : ST_STOP;
            else
               rx_bit_d = rx_bit_q + 1'b1;
         end
         ST_PARITY: if (rx_smp) begin
            rx_par_d = rx_s2_q;
            rx_st_d  = ST_STOP;
         end
         ST_STOP: if (rx_smp) begin
            rx_st_d   = ST_IDLE;
            rx_data_d = rx_sh_q;
            rx_fe_d   = !rx_s2_q;
            rx_pe_d   = PAR_EN && (rx_par_q != ((^rx_sh_q) ^ PAR_ODD));
            rx_vld_d  = 1'b1;
         end
         default: rx_st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_st_q   <= ST_IDLE;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '0;
         tx_par_q  <= 1'b0;
         tx_stop_q <= 1'b0;
         txd_q     <= 1'b1;
         tx_rdy_q  <= 1'b1;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= ST_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         rx_par_q  <= 1'b0;
         rx_vld_q  <= 1'b0;
         rx_fe_q   <= 1'b0;
         rx_pe_q   <= 1'b0;
      end else begin
         tx_st_q   <= tx_st_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_bit_q  <= tx_bit_d;
         tx_sh_q   <= tx_sh_d;
         tx_par_q  <= tx_par_d;
         tx_stop_q <= tx_stop_d;
         txd_q     <= txd_d;
         tx_rdy_q  <= tx_rdy_d;
         rx_s1_q   <= rxd;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         rx_par_q  <= rx_par_d;
         rx_vld_q  <= rx_vld_d;
         rx_fe_q   <= rx_fe_d;
         rx_pe_q   <= rx_pe_d;
      end
   end

   assign tx_ready      = tx_rdy_q;
   assign txd           = txd_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_vld_q;
   assign rx_frame_err  = rx_fe_q;
   assign rx_parity_err = rx_pe_q;

endmodule

// File: tb/tb_uart_transceiver_param.sv
// Bench for the parametrised UART: an 8N1 and an 8E1 instance, each
// looped back txd->rxd, with an override line for injected frames.
module tb_uart_transceiver_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tx_valid, sel, inj_en, inj;
   logic [7:0] tx_data;
   logic       rdy_a, txd_a, rxd_a, vld_a, fe_a, pe_a;
   logic       rdy_p, txd_p, rxd_p, vld_p, fe_p, pe_p;
   logic [7:0] rd_a, rd_p;
   logic       t_ready, t_txd;

   assign rxd_a   = (inj_en && !sel) ? inj : txd_a;
   assign rxd_p   = (inj_en && sel) ? inj : txd_p;
   assign t_ready = sel ? rdy_p : rdy_a;
   assign t_txd   = sel ? txd_p : txd_a;

   uart_transceiver_param #(
      .CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
   ) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data),
      .tx_valid(tx_valid && !sel), .tx_ready(rdy_a), .txd(txd_a),
      .rxd(rxd_a), .rx_data(rd_a), .rx_valid(vld_a),
      .rx_frame_err(fe_a), .rx_parity_err(pe_a)
   );

   uart_transceiver_param #(
      .CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
   ) dutp (
      .clk(clk), .rst(rst), .tx_data(tx_data),
      .tx_valid(tx_valid && sel), .tx_ready(rdy_p), .txd(txd_p),
      .rxd(rxd_p), .rx_data(rd_p), .rx_valid(vld_p),
      .rx_frame_err(fe_p), .rx_parity_err(pe_p)
   );

   typedef struct packed { logic [7:0] d; logic fe; logic pe; } rx_t;
   rx_t rxq_a[$], rxq_p[$];

   always @(negedge clk) begin
      if (vld_a) rxq_a.push_back(rx_t'({rd_a, fe_a, pe_a}));
      if (vld_p) rxq_p.push_back(rx_t'({rd_p, fe_p, pe_p}));
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Line image of one frame, bit i = i-th bit on the wire.
   function automatic logic [31:0] frame_of(input logic [7:0] d,
                                            input logic pe);
      logic [31:0] f;
      if (pe) f = {21'd0, 1'b1, ^d, d, 1'b0};
      else    f = {22'd0, 1'b1, d, 1'b0};
      return f;
   endfunction

   function automatic int qsize();
      return sel ? rxq_p.size() : rxq_a.size();
   endfunction

   task automatic chk_rx(input string nm, input logic [7:0] d,
                         input logic fe, input logic pe);
      rx_t r;
      if (qsize() == 0) begin
         chk({nm, "_rxcnt"}, 0, 1);
         return;
      end
      if (sel) r = rxq_p.pop_front();
      else     r = rxq_a.pop_front();
      chk({nm, "_rxdata"}, r.d, d);
      chk({nm, "_ferr"}, r.fe, fe);
      chk({nm, "_perr"}, r.pe, pe);
   endtask

   task automatic tx_burst(input int n, input logic [7:0] w0,
                           input logic [7:0] w1, input logic [31:0] exp,
                           input string nm);
      logic [31:0] f, l;
      int nb, fb, to;
      fb = sel ? 11 : 10;
      nb = fb * n;
      f = '0;
      l = '0;
      to = 0;
      @(negedge clk);
      tx_data = w0;
      tx_valid = 1'b1;
      while (!t_ready && to < 1000) begin
         @(negedge clk);
         to++;
      end
      chk({nm, "_rdy_timeout"}, to >= 1000, 0);
      @(posedge clk);
      for (int k = 0; k < nb; k++) begin
         for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (k == 0 && c == 0) begin
               chk({nm, "_busy"}, t_ready, 0);
               if (n == 1) tx_valid = 1'b0;
               else        tx_data = w1;
            end
            if (n == 2 && k == fb && c == 0) tx_valid = 1'b0;
            if (c == 0)  f[k] = t_txd;
            if (c == 15) l[k] = t_txd;
         end
      end
      chk({nm, "_rdy_end"}, t_ready, 1);
      chk({nm, "_bits_first"}, f, exp);
      chk({nm, "_bits_last"}, l, exp);
      repeat (4) @(negedge clk);
      chk_rx({nm, "_f0"}, w0, 0, 0);
      if (n == 2) chk_rx({nm, "_f1"}, w1, 0, 0);
      chk({nm, "_extra_rx"}, qsize(), 0);
   endtask

   task automatic inj_bits(input logic [31:0] b, input int nb);
      for (int k = 0; k < nb; k++) begin
         inj = b[k];
         repeat (16) @(negedge clk);
      end
   endtask

   typedef struct { logic s; logic [7:0] d; logic [31:0] f; } vec_t;
   vec_t tbl[6];

   initial begin
      logic [7:0] d0, d1;
      tbl[0] = '{1'b0, 8'h67, 32'h2CE};
      tbl[1] = '{1'b0, 8'h00, 32'h200};
      tbl[2] = '{1'b0, 8'hFF, 32'h3FE};
      tbl[3] = '{1'b0, 8'hA5, 32'h34A};
      tbl[4] = '{1'b1, 8'hF1, 32'h7E2};
      tbl[5] = '{1'b1, 8'h00, 32'h400};

      rst = 1'b0;
      tx_valid = 1'b0;
      tx_data = '0;
      sel = 1'b0;
      inj_en = 1'b0;
      inj = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_txd", txd_a, 1);
      chk("rst_ready", rdy_a, 1);
      chk("rst_rxvalid", vld_a, 0);
      chk("rst_rxdata", rd_a, 0);
      chk("rst_ferr", fe_a, 0);
      chk("rst_perr", pe_a, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         sel = tbl[i].s;
         tx_burst(1, tbl[i].d, 8'h00, tbl[i].f, "tbl");
      end

      sel = 1'b0;
      tx_burst(2, 8'h67, 8'hF1, 32'hF8ACE, "b2b");

      for (int i = 0; i < 8; i++) begin
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         sel = i[0];
         if (i < 6)
            tx_burst(1, d0, d1, frame_of(d0, sel), "rnd");
         else
            tx_burst(2, d0, d1,
                     (frame_of(d1, sel) << (sel ? 11 : 10)) |
                     frame_of(d0, sel), "rnd_b2b");
      end

      sel = 1'b1;
      inj = 1'b1;
      inj_en = 1'b1;
      repeat (4) @(negedge clk);
      inj_bits(frame_of(8'hF1, 1'b1) ^ 32'h200, 11);
      repeat (8) @(negedge clk);
      chk_rx("par_flip", 8'hF1, 0, 1);

      sel = 1'b0;
      repeat (4) @(negedge clk);
      inj_bits(frame_of(8'h55, 1'b0) & ~32'h200, 10);
      inj = 1'b0;
      repeat (48) @(negedge clk);
      chk("brk_rxcnt", qsize(), 1);
      chk_rx("brk", 8'h55, 1, 0);
      repeat (64) @(negedge clk);
      chk("brk_hold", qsize(), 0);
      inj = 1'b1;
      repeat (20) @(negedge clk);
      inj_bits(frame_of(8'h3C, 1'b0), 10);
      inj = 1'b1;
      repeat (8) @(negedge clk);
      chk_rx("after_brk", 8'h3C, 0, 0);
      inj = 1'b0;
      repeat (4) @(negedge clk);
      inj = 1'b1;
      repeat (60) @(negedge clk);
      chk("glitch", qsize(), 0);
      inj_en = 1'b0;
      repeat (4) @(negedge clk);

      tx_data = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (48) @(negedge clk);
      chk("midrst_busy", rdy_a, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_txd", txd_a, 1);
      chk("midrst_ready", rdy_a, 1);
      rst = 1'b1;
      repeat (200) @(negedge clk);
      chk("midrst_no_rx", rxq_a.size(), 0);
      chk("midrst_idle", txd_a, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
